// File: rtl/tinker_muldiv_pkg.sv
// Shared types and constants for the Tinker iterative multiply/divide unit.
// The optional early-out path is enabled by TINKER_MULDIV_EARLY_OUT_EN.
package tinker_muldiv_pkg;

  localparam logic [1:0] OPC_MUL  = 2'b00;
  localparam logic [1:0] OPC_MULH = 2'b01;
  localparam logic [1:0] OPC_DIV  = 2'b10;
  localparam logic [1:0] OPC_REM  = 2'b11;

  typedef enum logic [1:0] {
    OP_MUL  = OPC_MUL,
    OP_MULH = OPC_MULH,
    OP_DIV  = OPC_DIV,
    OP_REM  = OPC_REM
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Legal geometry: even width of at least 8, and a whole number of steps per clock.
  function automatic bit cfg_ok(input int xlen, input int unroll);
    return (xlen >= 8) && (xlen % 2 == 0) && (unroll >= 1) && (xlen % unroll == 0);
  endfunction

endpackage

// File: rtl/tinker_muldiv_step.sv
// One combinational radix-2 step: shift-add for multiply, restoring
// trial-subtract for divide. hi/lo hold product halves or remainder/quotient.
module tinker_muldiv_step
  import tinker_muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi_in,
  input  logic [XLEN-1:0] lo_in,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  logic [XLEN:0] sum;
  logic [XLEN:0] diff;

  always_comb begin
    sum  = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    // Partial remainder stays below the divisor, so bit XLEN of diff is a clean borrow.
    diff = {hi_in, lo_in[XLEN-1]} - {1'b0, opnd};
    if (is_div) begin
      if (!diff[XLEN]) begin
        hi_out = diff[XLEN-1:0];
        lo_out = {lo_in[XLEN-2:0], 1'b1};
      end else begin
        hi_out = {hi_in[XLEN-2:0], lo_in[XLEN-1]};
        lo_out = {lo_in[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_out = sum[XLEN:1];
      lo_out = {sum[0], lo_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/tinker_muldiv_unit.sv
// Iterative multiply/divide unit with valid/ready request and response.
// Define TINKER_MULDIV_EARLY_OUT_EN to finish trivial operations at accept.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// RUN   | UNROLL steps per clock, counter counts down to terminal count
// DONE  | result held on resp_* until resp_ready
module tinker_muldiv_unit
  import tinker_muldiv_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int UNROLL = 1,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic             req_signed,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_dbz
);

  localparam int N     = XLEN / UNROLL;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N);
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_DONE = ST_DONE;

  if (!cfg_ok(XLEN, UNROLL)) begin : g_cfg_err
    $error("tinker_muldiv_unit: XLEN must be even, >= 8 and a multiple of UNROLL");
  end

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  op_e              op_q;
  logic             neg_q;
  logic [XLEN-1:0]  hi_q;
  logic [XLEN-1:0]  lo_q;
  logic [XLEN-1:0]  opnd_q;

  logic             a_neg;
  logic             b_neg;
  logic [XLEN-1:0]  a_mag;
  logic [XLEN-1:0]  b_mag;
  logic             b_zero;

  assign a_neg  = req_signed & req_a[XLEN-1];
  assign b_neg  = req_signed & req_b[XLEN-1];
  assign a_mag  = a_neg ? (~req_a + 1'b1) : req_a;
  assign b_mag  = b_neg ? (~req_b + 1'b1) : req_b;
  assign b_zero = (req_b == '0);

  assign req_ready  = (state == S_IDLE) && !reset;
  assign resp_valid = (state == S_DONE);

  logic [XLEN-1:0] hi_ch [UNROLL+1];
  logic [XLEN-1:0] lo_ch [UNROLL+1];

  assign hi_ch[0] = hi_q;
  assign lo_ch[0] = lo_q;

  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    tinker_muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div (op_q[1]),
      .hi_in  (hi_ch[i]),
      .lo_in  (lo_ch[i]),
      .opnd   (opnd_q),
      .hi_out (hi_ch[i+1]),
      .lo_out (lo_ch[i+1])
    );
  end

  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   fix_data;

  // Signed results come from magnitudes; negating the full product keeps MUL sign-agnostic.
  always_comb begin
    prod     = {hi_ch[UNROLL], lo_ch[UNROLL]};
    prod_fix = neg_q ? (~prod + 1'b1) : prod;
    fix_data = '0;
    case (op_q)
      OP_MUL:  fix_data = prod_fix[XLEN-1:0];
      OP_MULH: fix_data = prod_fix[2*XLEN-1:XLEN];
      OP_DIV:  fix_data = neg_q ? (~lo_ch[UNROLL] + 1'b1) : lo_ch[UNROLL];
      default: fix_data = neg_q ? (~hi_ch[UNROLL] + 1'b1) : hi_ch[UNROLL];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      resp_data <= '0;
      resp_tag  <= '0;
      resp_dbz  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q     <= op_e'(req_op);
            resp_tag <= req_tag;
            resp_dbz <= 1'b0;
            hi_q     <= '0;
            if (req_op[1]) begin
              lo_q   <= a_mag;
              opnd_q <= b_mag;
              neg_q  <= (req_op == OPC_REM) ? a_neg : (a_neg ^ b_neg);
            end else begin
              lo_q   <= b_mag;
              opnd_q <= a_mag;
              neg_q  <= a_neg ^ b_neg;
            end
            if (req_op[1] && b_zero) begin
              state     <= S_DONE;
              resp_dbz  <= 1'b1;
              resp_data <= (req_op == OPC_DIV) ? {XLEN{1'b1}} : req_a;
            end
`ifdef TINKER_MULDIV_EARLY_OUT_EN
            else if (!req_op[1] && ((req_a == '0) || b_zero)) begin
              state     <= S_DONE;
              resp_data <= '0;
            end else if (req_op[1] && (a_mag < b_mag)) begin
              state     <= S_DONE;
              resp_data <= (req_op == OPC_DIV) ? '0 : req_a;
            end
`endif
            else begin
              state <= S_RUN;
              cnt   <= CNT_LOAD;
            end
          end
        end
        S_RUN: begin
          hi_q <= hi_ch[UNROLL];
          lo_q <= lo_ch[UNROLL];
          cnt  <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state     <= S_DONE;
            resp_data <= fix_data;
          end
        end
        S_DONE: begin
          if (resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinker_muldiv_unit.sv
// Directed bench for tinker_muldiv_unit: DUT 0 with UNROLL=1, DUT 1 with UNROLL=4.
// Latencies count rising edges from the accept edge (inclusive) to resp_valid seen high.
module tb_tinker_muldiv_unit;

  localparam int XLEN  = 64;
  localparam int TAG_W = 5;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic             req_valid  [2];
  logic             req_ready  [2];
  logic [1:0]       req_op     [2];
  logic             req_signed [2];
  logic [XLEN-1:0]  req_a      [2];
  logic [XLEN-1:0]  req_b      [2];
  logic [TAG_W-1:0] req_tag    [2];
  logic             resp_valid [2];
  logic             resp_ready [2];
  logic [XLEN-1:0]  resp_data  [2];
  logic [TAG_W-1:0] resp_tag   [2];
  logic             resp_dbz   [2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    tinker_muldiv_unit #(.XLEN(XLEN), .UNROLL(g == 0 ? 1 : 4), .TAG_W(TAG_W)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_op     (req_op[g]),
      .req_signed (req_signed[g]),
      .req_a      (req_a[g]),
      .req_b      (req_b[g]),
      .req_tag    (req_tag[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_data  (resp_data[g]),
      .resp_tag   (resp_tag[g]),
      .resp_dbz   (resp_dbz[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input int d, input logic [1:0] op, input logic sgn,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag);
    @(negedge clk);
    req_valid[d]  = 1'b1;
    req_op[d]     = op;
    req_signed[d] = sgn;
    req_a[d]      = a;
    req_b[d]      = b;
    req_tag[d]    = tag;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_resp(input int d, input int max, output int lat);
    lat = 1;
    while (!resp_valid[d] && lat < max) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("resp_valid_seen", 64'(resp_valid[d]), 64'd1);
  endtask

  task automatic ack(input int d);
    @(negedge clk);
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[d] = 1'b0;
    check("idle_after_ack", 64'(req_ready[d]), 64'd1);
  endtask

  task automatic run_op(input string name, input int d, input logic [1:0] op, input logic sgn,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag,
                        input logic [63:0] exp_data, input logic exp_dbz, input int exp_lat);
    int lat;
    issue(d, op, sgn, a, b, tag);
    wait_resp(d, 200, lat);
    check({name, "_data"}, resp_data[d], exp_data);
    check({name, "_dbz"}, 64'(resp_dbz[d]), 64'(exp_dbz));
    check({name, "_tag"}, 64'(resp_tag[d]), 64'(tag));
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    ack(d);
  endtask

  initial begin
    int seen;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_op[d] = 2'b00; req_signed[d] = 1'b0;
      req_a[d] = '0; req_b[d] = '0; req_tag[d] = '0; resp_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready[0]), 64'd0);
    check("rst_resp_valid", 64'(resp_valid[0]), 64'd0);
    check("rst_resp_data", resp_data[0], 64'd0);
    check("rst_resp_tag", 64'(resp_tag[0]), 64'd0);
    check("rst_resp_dbz", 64'(resp_dbz[0]), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_ready", 64'(req_ready[0]), 64'd1);

    // UNROLL=1: non-dbz ops take 64 RUN edges after the accept edge.
    run_op("mul_u",      0, 2'b00, 1'b0, 64'd7, 64'd6, 5'd3, 64'd42, 1'b0, 65);
    run_op("mul_s",      0, 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd4,
           64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 65);
    run_op("mulh_s_m1",  0, 2'b01, 1'b1, ONES, ONES, 5'd5, 64'd0, 1'b0, 65);
    run_op("mulh_u_max", 0, 2'b01, 1'b0, ONES, ONES, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 65);
    run_op("mulh_s_min", 0, 2'b01, 1'b1, MINV, 64'd2, 5'd7, ONES, 1'b0, 65);
    run_op("div_s",      0, 2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd8,
           64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 65);
    run_op("rem_s",      0, 2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9, ONES, 1'b0, 65);
    run_op("rem_s_bneg", 0, 2'b11, 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd10, 64'd1, 1'b0, 65);
    run_op("div_u",      0, 2'b10, 1'b0, 64'd100, 64'd7, 5'd11, 64'd14, 1'b0, 65);
    run_op("rem_u",      0, 2'b11, 1'b0, 64'd100, 64'd7, 5'd12, 64'd2, 1'b0, 65);
    run_op("div_dbz",    0, 2'b10, 1'b0, 64'd5, 64'd0, 5'd13, ONES, 1'b1, 1);
    run_op("rem_dbz",    0, 2'b11, 1'b1, 64'd5, 64'd0, 5'd14, 64'd5, 1'b1, 1);

    // Response held while the consumer stalls; no new request accepted.
    begin
      int lat;
      issue(0, 2'b00, 1'b0, 64'd3, 64'd4, 5'd15);
      wait_resp(0, 200, lat);
      for (int i = 0; i < 10; i++) begin
        @(posedge clk);
        #1;
        check("hold_valid", 64'(resp_valid[0]), 64'd1);
        check("hold_data", resp_data[0], 64'd12);
        check("hold_ready", 64'(req_ready[0]), 64'd0);
      end
      ack(0);
    end

    // Reset in the middle of RUN discards the operation.
    issue(0, 2'b00, 1'b0, 64'd7, 64'd6, 5'd16);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_run_ready_low", 64'(req_ready[0]), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_run_ready", 64'(req_ready[0]), 64'd1);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid[0]) seen++;
    end
    check("rst_run_no_resp", 64'(seen), 64'd0);

    // UNROLL=4: 16 RUN edges after accept.
    run_op("u4_div_ovf", 1, 2'b10, 1'b1, MINV, ONES, 5'd17, MINV, 1'b0, 17);
    run_op("u4_rem_ovf", 1, 2'b11, 1'b1, MINV, ONES, 5'd18, 64'd0, 1'b0, 17);
`ifdef TINKER_MULDIV_EARLY_OUT_EN
    run_op("u4_mul_zero", 1, 2'b00, 1'b0, 64'd0, 64'd9, 5'd19, 64'd0, 1'b0, 1);
    run_op("u4_rem_small", 1, 2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd10, 5'd20,
           64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1);
`else
    run_op("u4_mul_zero", 1, 2'b00, 1'b0, 64'd0, 64'd9, 5'd19, 64'd0, 1'b0, 17);
    run_op("u4_rem_small", 1, 2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd10, 5'd20,
           64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 17);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tinker_muldiv_unit.md
Name: tinker_muldiv_unit

Overview:
Iterative multi-cycle integer multiply/divide unit for the Tinker core. It replaces the single-cycle `*` and `/` paths of the combinational ALU.
- Generalised in operand width and bits-per-cycle.
- Adds signed mode, high-half multiply and remainder.
- Defines divide-by-zero behaviour.
- Uses valid/ready request and response handshakes so the core can stall on it.

Parameters:
XLEN, 64, operand/result width in bits; must be even and ≥8.
UNROLL, 1, radix-2 steps per clock; must divide XLEN.
TAG_W, 5, width of pass-through tag (destination register index).

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; sampled on rising edge of clk
req_valid  in  1  request present
req_ready  out  1  unit can accept request
req_op  in  2  00 MUL (low XLEN), 01 MULH (high XLEN), 10 DIV, 11 REM
req_signed  in  1  1 = two's-complement operands, 0 = unsigned
req_a  in  XLEN  multiplicand / dividend
req_b  in  XLEN  multiplier / divisor
req_tag  in  TAG_W  returned unchanged with result
resp_valid  out  1  result present
resp_ready  in  1  consumer accepts result
resp_data  out  XLEN  result
resp_tag  out  TAG_W  tag of the request
resp_dbz  out  1  divide-by-zero flag, valid with resp_valid

Behaviour:
- States: IDLE, RUN, DONE. Define N = XLEN/UNROLL.
- Reset (edge with reset=1): state → IDLE; resp_valid, resp_dbz, resp_data, resp_tag → 0; counter → 0.
  - Reset mid-RUN or mid-DONE discards the operation; no response is produced.
  - req_ready = 0 while reset is high.
- req_ready = 1 only in IDLE. Accept happens on an edge with req_valid && req_ready; operands, op, signed and tag are registered at that edge.
- IDLE→RUN on accept. Signed mode stores operand magnitudes plus result sign:
  - MUL/MULH: sign = sign(a) ^ sign(b).
  - DIV: sign = sign(a) ^ sign(b).
  - REM: sign = sign(a).
- RUN: each edge performs UNROLL steps and decrements the counter.
  - Multiply: shift-add into a 2·XLEN product.
  - Divide: restoring shift-subtract, giving quotient and remainder.
  - On the N-th RUN edge the sign fix-up is applied, the selected half/quotient/remainder is written to resp_data, and state → DONE.
  - resp_valid is therefore first high in the cycle after the N-th edge following the accept edge.
- Divide by zero (DIV/REM, b=0), detected at accept. Next state is DONE directly (resp_valid on the first edge after accept), with resp_dbz=1.
  - DIV result: all ones.
  - REM result: a.
- Signed overflow (DIV, a = most negative, b = −1): quotient = most negative, REM = 0, resp_dbz=0. This falls out of the normal fix-up; no special path.
- MUL returns the low XLEN of the product and is identical signed or unsigned. MULH returns the high XLEN, signed or unsigned per req_signed.
- DONE: resp_valid held at 1 with resp_data, resp_tag and resp_dbz stable until an edge with resp_ready=1, then state → IDLE.
  - One bubble: no request can be accepted in the DONE cycle.
- resp_ready is ignored outside DONE. req_* inputs are ignored outside IDLE.

Optional Feature:
TINKER_MULDIV_EARLY_OUT_EN
- Defined: at accept, the unit goes directly to DONE (resp_valid on the first edge after accept) in two cases:
  - MUL/MULH with either operand 0: result 0.
  - DIV/REM with |a| < |b| and b≠0: quotient 0, remainder = a.
- Not defined: all non-dbz operations take exactly N RUN edges; latency is fixed and data-independent.

Decomposition:
- Package tinker_muldiv_pkg:
  - op enum (MUL, MULH, DIV, REM).
  - state enum (IDLE, RUN, DONE).
  - Op encoding constants.
  - Elaboration-time checks: XLEN%UNROLL==0.
- Sub-module tinker_muldiv_step: one combinational radix-2 step (add-or-hold for multiply; trial-subtract for divide), instantiated UNROLL times in a generate chain.

Test Plan:
- XLEN=64, UNROLL=1, MUL unsigned a=7, b=6, tag=3 → resp_data=42, resp_tag=3, resp_valid first high 64 edges after accept, resp_dbz=0.
- MULH signed a=−1, b=−1 → resp_data=0. MULH unsigned a=b=0xFFFF_FFFF_FFFF_FFFF → resp_data=0xFFFF_FFFF_FFFF_FFFE.
- DIV signed a=−7, b=2 → resp_data=−3. REM signed a=−7, b=2 → resp_data=−1. DIV unsigned a=100, b=7 → resp_data=14.
- DIV b=0, a=5 → resp_data=all ones, resp_dbz=1, resp_valid one edge after accept. REM b=0, a=5 → resp_data=5, resp_dbz=1.
- Hold resp_ready=0 for 10 cycles in DONE → resp_valid and resp_data stable and req_ready=0 throughout. Assert reset during RUN → no response, req_ready=1 the cycle after reset deasserts.
- UNROLL=4: DIV signed a=0x8000_0000_0000_0000, b=−1 → resp_data=0x8000_0000_0000_0000, resp_valid 16 edges after accept. With TINKER_MULDIV_EARLY_OUT_EN, MUL a=0, b=9 → resp_data=0 one edge after accept.
